// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - funct3 encodings, MEM-stage state and access legality helper
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} state_t;

  // True when an access is requested but cannot legally be issued to memory.
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    bad = (rd & wr)
        | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111)
        | (wr & f3[2])
        | ((f3[1:0] == 2'b01) & off[0])
        | ((f3[1:0] == 2'b10) & (off != 2'b00));
    return (rd | wr) & bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a read word and extends it
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage: req/ack data-memory FSM, lanes, MEM/WB registers
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] MUX_result_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  instr_11_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        mem_fault_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALU_result_o,
  output logic [31:0] Mem_data_o,
  output logic [4:0]  instr_11_o
);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_req, r_we, r_fault;
  logic [31:0] r_addr, r_wdata, r_alu;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic        r_regwrite, r_memtoreg;
  logic        r_wb_regwrite, r_wb_memtoreg;
  logic [31:0] r_wb_alu, r_wb_data;
  logic [4:0]  r_wb_rd;

  logic        w_access, w_fault, w_timeout, w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;

  assign w_access  = MemRead_i | MemWrite_i;
  assign w_fault   = access_fault(MemRead_i, MemWrite_i, funct3_i, ALU_result_i[1:0]);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

  // Loads always fetch the whole word; only stores narrow the lanes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (MemWrite_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ALU_result_i[1:0];
          w_wdata = {4{MUX_result_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {ALU_result_i[1], 1'b0};
          w_wdata = {2{MUX_result_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = MUX_result_i;
        end
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata  (dmem_rdata_i),
    .i_funct3 (r_f3),
    .i_offset (r_off),
    .o_data   (w_load_data)
  );

  always_comb begin
    w_stall = 1'b0;
    if (!rst_i) begin
      case (r_state)
        IDLE:    w_stall = w_access & ~w_fault;
        BUSY:    w_stall = ~dmem_ack_i;
        default: w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cnt         <= 32'h0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_fault       <= 1'b0;
      r_addr        <= 32'h0;
      r_wdata       <= 32'h0;
      r_alu         <= 32'h0;
      r_be          <= 4'h0;
      r_f3          <= 3'h0;
      r_off         <= 2'h0;
      r_rd          <= 5'h0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_alu      <= 32'h0;
      r_wb_data     <= 32'h0;
      r_wb_rd       <= 5'h0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_access) begin
            r_wb_regwrite <= RegWrite_i;
            r_wb_memtoreg <= MemtoReg_i;
            r_wb_alu      <= ALU_result_i;
            r_wb_rd       <= instr_11_i;
            r_wb_data     <= 32'h0;
          end else if (w_fault) begin
            r_wb_regwrite <= 1'b0;
            r_fault       <= 1'b1;
          end else begin
            r_addr        <= {ALU_result_i[31:2], 2'b00};
            r_alu         <= ALU_result_i;
            r_we          <= MemWrite_i;
            r_be          <= w_be;
            r_wdata       <= w_wdata;
            r_f3          <= funct3_i;
            r_off         <= ALU_result_i[1:0];
            r_rd          <= instr_11_i;
            r_regwrite    <= RegWrite_i;
            r_memtoreg    <= MemtoReg_i;
            r_req         <= 1'b1;
            r_wb_regwrite <= 1'b0;
            r_cnt         <= 32'h0;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          // Ack has priority over a timeout landing on the same cycle.
          if (dmem_ack_i) begin
            r_req         <= 1'b0;
            r_wb_regwrite <= r_regwrite;
            r_wb_memtoreg <= r_memtoreg;
            r_wb_alu      <= r_alu;
            r_wb_rd       <= r_rd;
            r_wb_data     <= r_we ? 32'h0 : w_load_data;
            r_cnt         <= 32'h0;
            r_state       <= IDLE;
          end else if (w_timeout) begin
            r_req         <= 1'b0;
            r_fault       <= 1'b1;
            r_wb_regwrite <= 1'b0;
            r_cnt         <= 32'h0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 32'h1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;
  assign stall_o      = w_stall;
  assign mem_fault_o  = r_fault;
  assign RegWrite_o   = r_wb_regwrite;
  assign MemtoReg_o   = r_wb_memtoreg;
  assign ALU_result_o = r_wb_alu;
  assign Mem_data_o   = r_wb_data;
  assign instr_11_o   = r_wb_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALU_result_i, MUX_result_i;
  logic [2:0]  funct3_i;
  logic [4:0]  instr_11_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, mem_fault_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ALU_result_o, Mem_data_o;
  logic [4:0]  instr_11_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALU_result_i(ALU_result_i), .MUX_result_i(MUX_result_i), .funct3_i(funct3_i), .instr_11_i(instr_11_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .mem_fault_o(mem_fault_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALU_result_o(ALU_result_o), .Mem_data_o(Mem_data_o), .instr_11_o(instr_11_o)
  );

  // Reference model: access size in bytes and legality from the ISA rules.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic is_legal(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a);
    logic ok_f3;
    if (mr && mw) return 1'b0;
    ok_f3 = mr ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 == 0 || f3 == 1 || f3 == 2);
    return ok_f3 && ((a % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic mw, input logic [2:0] f3, input logic [31:0] a);
    int mask;
    if (!mw) return 4'hF;
    mask = (1 << size_of(f3)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ALU_result_i = 0; MUX_result_i = 0; funct3_i = 0; instr_11_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic scramble_inputs;
    RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom); MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom);
    ALU_result_i = $urandom; MUX_result_i = $urandom; funct3_i = 3'($urandom); instr_11_i = 5'($urandom);
  endtask

  // One legal transaction; nbusy counts BUSY cycles including the ack cycle.
  task automatic do_access(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input logic rw, input logic m2r, input logic [4:0] rd, input int nbusy,
                           input logic stray);
    int stalls;
    logic [31:0] e_data;
    stalls = 0;
    e_data = mw ? 32'h0 : exp_load(f3, a, rdat);
    RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    ALU_result_i = a; MUX_result_i = sd; funct3_i = f3; instr_11_i = rd;
    dmem_ack_i = stray; dmem_rdata_i = $urandom;
    #1;
    if (stall_o) stalls++;
    tick;
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, RegWrite_o, mem_fault_o} !==
        {1'b1, mw, a & 32'hFFFF_FFFC, exp_be(mw, f3, a), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_issue: req=%b we=%b addr=%h be=%b rw=%b flt=%b want we=%b addr=%h be=%b", nm,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, RegWrite_o, mem_fault_o,
               mw, a & 32'hFFFF_FFFC, exp_be(mw, f3, a));
    end
    if (mw) begin
      n_cmp++;
      if (dmem_wdata_o !== exp_wdata(f3, sd)) begin
        n_err++;
        $display("FAIL %s_wdata: got %h want %h", nm, dmem_wdata_o, exp_wdata(f3, sd));
      end
    end
    for (int k = 1; k <= nbusy; k++) begin
      scramble_inputs();
      dmem_ack_i = (k == nbusy);
      dmem_rdata_i = (k == nbusy) ? rdat : $urandom;
      #1;
      if (stall_o) stalls++;
      tick;
      if (k < nbusy) begin
        n_cmp++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== (a & 32'hFFFF_FFFC)) begin
          n_err++;
          $display("FAIL %s_hold%0d: req=%b addr=%h want req=1 addr=%h", nm, k, dmem_req_o, dmem_addr_o,
                   a & 32'hFFFF_FFFC);
        end
      end
    end
    drive_idle();
    n_cmp++;
    if (stalls !== nbusy) begin
      n_err++;
      $display("FAIL %s_stall_cycles: got %0d want %0d", nm, stalls, nbusy);
    end
    n_cmp++;
    if ({dmem_req_o, mem_fault_o, RegWrite_o, MemtoReg_o, instr_11_o, ALU_result_o, Mem_data_o} !==
        {1'b0, 1'b0, rw, m2r, rd, a, e_data}) begin
      n_err++;
      $display("FAIL %s_wb: req=%b flt=%b rw=%b m2r=%b rd=%0d alu=%h data=%h want rw=%b m2r=%b rd=%0d alu=%h data=%h",
               nm, dmem_req_o, mem_fault_o, RegWrite_o, MemtoReg_o, instr_11_o, ALU_result_o, Mem_data_o,
               rw, m2r, rd, a, e_data);
    end
  endtask

  task automatic alu_op(input string nm, input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [31:0] alu, input logic ack);
    RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = 0; MemWrite_i = 0;
    ALU_result_i = alu; MUX_result_i = $urandom; funct3_i = 3'($urandom); instr_11_i = rd;
    dmem_ack_i = ack; dmem_rdata_i = $urandom;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stall: got %b want 0", nm, stall_o);
    end
    tick;
    n_cmp++;
    if ({dmem_req_o, mem_fault_o, RegWrite_o, MemtoReg_o, instr_11_o, ALU_result_o, Mem_data_o} !==
        {1'b0, 1'b0, rw, m2r, rd, alu, 32'h0}) begin
      n_err++;
      $display("FAIL %s_pass: req=%b flt=%b rw=%b m2r=%b rd=%0d alu=%h data=%h want rw=%b m2r=%b rd=%0d alu=%h",
               nm, dmem_req_o, mem_fault_o, RegWrite_o, MemtoReg_o, instr_11_o, ALU_result_o, Mem_data_o,
               rw, m2r, rd, alu);
    end
    drive_idle();
  endtask

  task automatic check_all_zero(input string nm);
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, stall_o, mem_fault_o, RegWrite_o,
         MemtoReg_o, ALU_result_o, Mem_data_o, instr_11_o} !== '0) begin
      n_err++;
      $display("FAIL %s: req=%b we=%b addr=%h wd=%h be=%b stall=%b flt=%b rw=%b m2r=%b alu=%h data=%h rd=%0d want all 0",
               nm, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, stall_o, mem_fault_o,
               RegWrite_o, MemtoReg_o, ALU_result_o, Mem_data_o, instr_11_o);
    end
  endtask

  task automatic fault_op(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] a);
    RegWrite_i = 1; MemtoReg_i = mr; MemRead_i = mr; MemWrite_i = mw;
    ALU_result_i = a; MUX_result_i = $urandom; funct3_i = f3; instr_11_i = 5'($urandom);
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stall: got %b want 0", nm, stall_o);
    end
    tick;
    drive_idle();
    n_cmp++;
    if ({mem_fault_o, dmem_req_o, RegWrite_o} !== 3'b100) begin
      n_err++;
      $display("FAIL %s_pulse: flt=%b req=%b rw=%b want 1 0 0", nm, mem_fault_o, dmem_req_o, RegWrite_o);
    end
    tick;
    n_cmp++;
    if (mem_fault_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_clear: flt=%b want 0", nm, mem_fault_o);
    end
  endtask

  task automatic test_reset;
    drive_idle();
    rst_i = 1;
    tick;
    tick;
    check_all_zero("reset_state");
    rst_i = 0;
  endtask

  task automatic test_alu;
    alu_op("alu_directed", 1'b1, 1'b0, 5'd5, 32'h1234, 1'b0);
    for (int i = 0; i < 8; i++)
      alu_op("alu_rand", 1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'b0);
  endtask

  task automatic test_directed_mem;
    do_access("lb_0x103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 1, 5'd3, 4, 0);
    do_access("sh_0x102", 0, 1, 3'b001, 32'h102, 32'hABCD, 32'h0, 0, 0, 5'd0, 2, 0);
    n_cmp++;
    if (Mem_data_o !== 32'hFFFF_FF80 - 32'hFFFF_FF80) begin
      n_err++;
      $display("FAIL sh_mem_data: got %h want 0", Mem_data_o);
    end
  endtask

  task automatic test_random_access;
    logic mr, mw;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      mr = 1'($urandom);
      mw = ~mr;
      do begin
        f3 = 3'($urandom);
        a = $urandom & 32'h0000_FFFF;
      end while (!is_legal(mr, mw, f3, a));
      do_access("rand_mem", mr, mw, f3, a, $urandom, $urandom, 1'($urandom), 1'($urandom),
                5'($urandom), int'($urandom_range(1, 4)), 0);
    end
  endtask

  task automatic test_fault;
    logic mr, mw;
    logic [2:0] f3;
    logic [31:0] a;
    fault_op("lw_0x101", 1, 0, 3'b010, 32'h101);
    for (int i = 0; i < 10; i++) begin
      do begin
        mr = 1'($urandom); mw = 1'($urandom); f3 = 3'($urandom); a = $urandom;
      end while (!(mr || mw) || is_legal(mr, mw, f3, a));
      fault_op("fault_rand", mr, mw, f3, a);
    end
  endtask

  task automatic test_timeout;
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALU_result_i = 32'h200; funct3_i = 3'b010; instr_11_i = 5'd8;
    tick;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (dmem_req_o !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_wait%0d: req=%b want 1", k, dmem_req_o);
      end
      tick;
    end
    n_cmp++;
    if ({dmem_req_o, mem_fault_o, RegWrite_o, stall_o} !== 4'b0100) begin
      n_err++;
      $display("FAIL timeout_abort: req=%b flt=%b rw=%b stall=%b want 0 1 0 0", dmem_req_o, mem_fault_o,
               RegWrite_o, stall_o);
    end
    alu_op("stray_ack_idle", 1'b1, 1'b0, 5'd9, 32'h0000_5A5A, 1'b1);
    do_access("stray_ack_accept", 1, 0, 3'b101, 32'h402, 32'h0, 32'h8001_7FFF, 1, 1, 5'd4, 1, 1);
  endtask

  task automatic test_reset_mid;
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALU_result_i = 32'h300; funct3_i = 3'b010; instr_11_i = 5'd6;
    tick;
    drive_idle();
    n_cmp++;
    if (dmem_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_busy: req=%b want 1", dmem_req_o);
    end
    rst_i = 1;
    tick;
    check_all_zero("rst_mid_state");
    rst_i = 0;
    alu_op("rst_mid_after", 1'b1, 1'b0, 5'd7, 32'h0000_CAFE, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    drive_idle();
    test_reset();
    test_alu();
    test_directed_mem();
    test_fault();
    test_random_access();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
